axi_fifo_rd_param: RTL and testbench

Parametrised AXI4 read-path FIFO inserted between an upstream AXI master (s_axi side) and a downstream slave (m_axi side).
- Buffers R-channel beats {rid, rdata, rresp, rlast} in a configurable-depth FIFO.
- Optionally holds each AR request until the FIFO has reserved room for its whole burst, so the R channel never stalls the downstream slave.
- Generalises the existing 32-bit fixed read FIFO in data/ID width, depth and AR mode, and adds a registered output stage and an occupancy output.

---
 rtl/axi_fifo_pkg.sv | 24 ++
 rtl/axi_sync_fifo.sv | 74 +++++++
 rtl/axi_fifo_rd_param.sv | 169 ++++++++++++++++
 tb/tb_axi_fifo_rd_param.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared AXI encodings, AR-path state type and pointer-width helper for the read FIFO.
package axi_fifo_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    AR_IDLE  = 2'd0,
    AR_WAIT  = 2'd1,
    AR_ISSUE = 2'd2
  } ar_state_e;

  // One extra bit over the address width distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO with a registered output stage; count reports memory occupancy only.
module axi_sync_fifo
  import axi_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             full, empty, push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = in_valid && !full;
  // Refill the output stage whenever it is empty or being drained.
  assign pop   = (!valid_q || out_ready) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    valid_d  = valid_q;
    data_d   = data_q;
    if (pop) begin
      valid_d = 1'b1;
      data_d  = mem_q[rd_ptr_q[AW-1:0]];
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Storage and payload register carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
    data_q <= data_d;
  end

  assign in_ready  = !full;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign count     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/axi_fifo_rd_param.sv
// AXI4 read-path FIFO: buffers R beats and optionally holds AR until burst space is reserved.
module axi_fifo_rd_param
  import axi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned DELAY_AR   = 1
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [ID_WIDTH-1:0]         s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic [3:0]                  s_axi_arcache,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [ID_WIDTH-1:0]         s_axi_rid,
  output logic [DATA_WIDTH-1:0]       s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,

  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic [3:0]                  m_axi_arcache,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,

  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam int unsigned RW = ID_WIDTH + DATA_WIDTH + 3;

  ar_state_e             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  arvalid_q, arvalid_d;
  logic [PW-1:0]         count_q, count_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [3:0]            arcache_q, arcache_d;

  logic [8:0]            beats_raw;
  logic [PW-1:0]         beats;
  logic                  fits, reserve, rd_fire;
  logic [PW-1:0]         count_sum;
  logic [RW-1:0]         r_out;

  // Burst length saturated to the FIFO depth; oversize bursts wait for an idle reservation.
  assign beats_raw = {1'b0, arlen_q} + 9'd1;
  assign beats     = (32'(beats_raw) > FIFO_DEPTH) ? PW'(FIFO_DEPTH) : PW'(beats_raw);
  assign fits      = (32'(count_q) + 32'(beats)) <= FIFO_DEPTH;
  assign rd_fire   = s_axi_rvalid && s_axi_rready;

  always_comb begin
    state_d = state_q;
    reserve = 1'b0;
    unique case (state_q)
      AR_IDLE:  if (s_axi_arvalid && arready_q) state_d = AR_WAIT;
      AR_WAIT: begin
        if (fits) begin
          state_d = AR_ISSUE;
          reserve = 1'b1;
        end
      end
      AR_ISSUE: if (m_axi_arready) state_d = AR_IDLE;
      default:  state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (state_d == AR_IDLE);
    arvalid_d = (state_d == AR_ISSUE);
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arcache_d = arcache_q;
    if (state_q == AR_IDLE && state_d == AR_WAIT) begin
      arid_d    = s_axi_arid;
      araddr_d  = s_axi_araddr;
      arlen_d   = s_axi_arlen;
      arsize_d  = s_axi_arsize;
      arburst_d = s_axi_arburst;
      arcache_d = s_axi_arcache;
    end
  end

  // Reservation and drain in the same cycle net together, floored at zero.
  always_comb begin
    count_sum = count_q + (reserve ? beats : PW'(0));
    count_d   = count_sum;
    if (rd_fire && count_sum != '0) begin
      count_d = count_sum - PW'(1);
    end
    if (DELAY_AR == 0) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= AR_IDLE;
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      arvalid_q <= arvalid_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    arid_q    <= arid_d;
    araddr_q  <= araddr_d;
    arlen_q   <= arlen_d;
    arsize_q  <= arsize_d;
    arburst_q <= arburst_d;
    arcache_q <= arcache_d;
  end

  assign s_axi_arready = (DELAY_AR != 0) ? arready_q : m_axi_arready;
  assign m_axi_arvalid = (DELAY_AR != 0) ? arvalid_q : s_axi_arvalid;
  assign m_axi_arid    = (DELAY_AR != 0) ? arid_q    : s_axi_arid;
  assign m_axi_araddr  = (DELAY_AR != 0) ? araddr_q  : s_axi_araddr;
  assign m_axi_arlen   = (DELAY_AR != 0) ? arlen_q   : s_axi_arlen;
  assign m_axi_arsize  = (DELAY_AR != 0) ? arsize_q  : s_axi_arsize;
  assign m_axi_arburst = (DELAY_AR != 0) ? arburst_q : s_axi_arburst;
  assign m_axi_arcache = (DELAY_AR != 0) ? arcache_q : s_axi_arcache;

  axi_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_r_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
    .in_valid  (m_axi_rvalid),
    .in_ready  (m_axi_rready),
    .out_data  (r_out),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready),
    .count     (fifo_count)
  );

  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

endmodule

// File: tb/tb_axi_fifo_rd_param.sv
// Directed bench for axi_fifo_rd_param: default reserving instance plus a 64-bit pass-through instance.
module tb_axi_fifo_rd_param;
  import axi_fifo_pkg::*;

  typedef logic [127:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: DELAY_AR=1, 32-bit data, 8-bit ID, depth 32
  logic [7:0]  s_arid, m_arid, s_rid, m_rid;
  logic [31:0] s_araddr, m_araddr, s_rdata, m_rdata;
  logic [7:0]  s_arlen, m_arlen;
  logic [2:0]  s_arsize, m_arsize;
  logic [1:0]  s_arburst, m_arburst, s_rresp, m_rresp;
  logic [3:0]  s_arcache, m_arcache;
  logic        s_arvalid, s_arready, m_arvalid, m_arready;
  logic        s_rlast, s_rvalid, s_rready, m_rlast, m_rvalid, m_rready;
  logic [5:0]  fcount;

  // Instance b: DELAY_AR=0, 64-bit data, 4-bit ID
  logic [3:0]  b_s_arid, b_m_arid, b_s_rid, b_m_rid;
  logic [31:0] b_s_araddr, b_m_araddr;
  logic [63:0] b_s_rdata, b_m_rdata;
  logic [7:0]  b_s_arlen, b_m_arlen;
  logic [2:0]  b_s_arsize, b_m_arsize;
  logic [1:0]  b_s_arburst, b_m_arburst, b_s_rresp, b_m_rresp;
  logic [3:0]  b_s_arcache, b_m_arcache;
  logic        b_s_arvalid, b_s_arready, b_m_arvalid, b_m_arready;
  logic        b_s_rlast, b_s_rvalid, b_s_rready, b_m_rlast, b_m_rvalid, b_m_rready;
  logic [5:0]  b_fcount;

  axi_fifo_rd_param dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
    .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arcache(s_arcache),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arcache(m_arcache),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .fifo_count(fcount)
  );

  axi_fifo_rd_param #(
    .DATA_WIDTH(64), .ID_WIDTH(4), .ADDR_WIDTH(32), .FIFO_DEPTH(32), .DELAY_AR(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_axi_arid(b_s_arid), .s_axi_araddr(b_s_araddr), .s_axi_arlen(b_s_arlen),
    .s_axi_arsize(b_s_arsize), .s_axi_arburst(b_s_arburst), .s_axi_arcache(b_s_arcache),
    .s_axi_arvalid(b_s_arvalid), .s_axi_arready(b_s_arready),
    .s_axi_rid(b_s_rid), .s_axi_rdata(b_s_rdata), .s_axi_rresp(b_s_rresp), .s_axi_rlast(b_s_rlast),
    .s_axi_rvalid(b_s_rvalid), .s_axi_rready(b_s_rready),
    .m_axi_arid(b_m_arid), .m_axi_araddr(b_m_araddr), .m_axi_arlen(b_m_arlen),
    .m_axi_arsize(b_m_arsize), .m_axi_arburst(b_m_arburst), .m_axi_arcache(b_m_arcache),
    .m_axi_arvalid(b_m_arvalid), .m_axi_arready(b_m_arready),
    .m_axi_rid(b_m_rid), .m_axi_rdata(b_m_rdata), .m_axi_rresp(b_m_rresp), .m_axi_rlast(b_m_rlast),
    .m_axi_rvalid(b_m_rvalid), .m_axi_rready(b_m_rready),
    .fifo_count(b_fcount)
  );

  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop-then-push so a beat can never match an entry pushed in the same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_rvalid && s_rready) begin
        vec_t exp;
        exp = (sb.size() != 0) ? sb.pop_front() : '1;
        chk("r_beat", 128'({s_rid, s_rdata, s_rresp, s_rlast}), exp);
      end
      if (m_rvalid && m_rready) begin
        sb.push_back(128'({m_rid, m_rdata, m_rresp, m_rlast}));
      end
    end
  end

  task automatic drive_beat(input logic [7:0] id, input logic [31:0] data, input logic last);
    m_rvalid = 1'b1;
    m_rid    = id;
    m_rdata  = data;
    m_rresp  = RESP_OKAY;
    m_rlast  = last;
  endtask

  task automatic send_ar(input logic [7:0] len, input logic [7:0] id);
    logic got;
    got       = 1'b0;
    s_arvalid = 1'b1;
    s_arid    = id;
    s_araddr  = {id, 24'h000100};
    s_arlen   = len;
    s_arsize  = 3'd2;
    s_arburst = BURST_INCR;
    s_arcache = 4'h3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = s_arready;
      tick();
      if (got) break;
    end
    s_arvalid = 1'b0;
    chk("ar_accept", 128'(got), 128'(1'b1));
  endtask

  task automatic take_ar(input string tag, input logic [7:0] id, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      seen = m_arvalid;
      tick();
      if (seen) break;
    end
    chk(tag, 128'(seen), 128'(1'b1));
    chk({tag, "_id"}, 128'(m_arid), 128'(id));
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    s_rready = 1'b1;
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    s_rready = 1'b0;
    @(negedge clk);
    chk({tag, "_sb_left"}, 128'(sb.size()), 128'(0));
    chk({tag, "_count"}, 128'(fcount), 128'(0));
    chk({tag, "_rvalid"}, 128'(s_rvalid), 128'(1'b0));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_n;
    logic        acc;
    logic [31:0] d;

    rst = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arcache = '0;
    s_arvalid = 1'b0; s_rready = 1'b0; m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    b_s_arid = '0; b_s_araddr = '0; b_s_arlen = '0; b_s_arsize = '0; b_s_arburst = '0;
    b_s_arcache = '0; b_s_arvalid = 1'b0; b_s_rready = 1'b0; b_m_arready = 1'b0;
    b_m_rid = '0; b_m_rdata = '0; b_m_rresp = '0; b_m_rlast = 1'b0; b_m_rvalid = 1'b0;
    sb.delete();

    // Reset values
    repeat (2) tick();
    chk("rst_rvalid", 128'(s_rvalid), 128'(1'b0));
    chk("rst_arvalid", 128'(m_arvalid), 128'(1'b0));
    chk("rst_arready", 128'(s_arready), 128'(1'b0));
    chk("rst_count", 128'(fcount), 128'(0));
    chk("rst_b_rvalid", 128'(b_s_rvalid), 128'(1'b0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("arready_after_rst", 128'(s_arready), 128'(1'b1));
    tick();

    // Single burst: arlen=3, id 0x5A
    s_arvalid = 1'b1; s_arid = 8'h5A; s_araddr = 32'h0000_1000; s_arlen = 8'd3;
    s_arsize = 3'd2; s_arburst = BURST_INCR; s_arcache = 4'h0;
    @(negedge clk);
    chk("ar1_arready", 128'(s_arready), 128'(1'b1));
    tick();
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("ar1_wait_lat", 128'(m_arvalid), 128'(1'b0));
    chk("ar1_arready_low", 128'(s_arready), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("ar1_issue", 128'(m_arvalid), 128'(1'b1));
    chk("ar1_id", 128'(m_arid), 128'(8'h5A));
    chk("ar1_addr", 128'(m_araddr), 128'(32'h0000_1000));
    chk("ar1_len", 128'(m_arlen), 128'(8'd3));
    chk("ar1_burst", 128'(m_arburst), 128'(BURST_INCR));
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    @(negedge clk);
    chk("ar1_done", 128'(m_arvalid), 128'(1'b0));
    chk("ar1_idle_ready", 128'(s_arready), 128'(1'b1));
    tick();
    s_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(8'h5A, 32'(32'h11 * (i + 1)), (i == 3));
      @(negedge clk);
      chk("r_first_lat", 128'(s_rvalid), 128'(i >= 2));
      tick();
    end
    m_rvalid = 1'b0;
    drain("burst1", 20);

    // Fill the memory with the consumer stalled
    s_rready = 1'b0;
    d = 32'h1000_0000;
    acc_n = 0;
    for (int c = 0; c < 40; c++) begin
      drive_beat(8'h20, d, 1'b0);
      @(negedge clk);
      acc = m_rready;
      tick();
      if (!acc) break;
      acc_n++;
      d++;
    end
    m_rvalid = 1'b0;
    chk("fill_accepted", 128'(acc_n), 128'(33));
    @(negedge clk);
    chk("fill_count", 128'(fcount), 128'(32));
    chk("fill_rready", 128'(m_rready), 128'(1'b0));
    tick();
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    @(negedge clk);
    chk("pop_rready_rise", 128'(m_rready), 128'(1'b1));
    chk("pop_count", 128'(fcount), 128'(31));
    tick();
    drain("fill", 100);

    // Reservation: 24 beats reserved, 16-beat burst held until 16 remain reserved
    send_ar(8'd23, 8'h01);
    take_ar("res_ar1", 8'h01, 5);
    send_ar(8'd15, 8'h02);
    repeat (4) tick();
    @(negedge clk);
    chk("res_ar2_held", 128'(m_arvalid), 128'(1'b0));
    tick();
    for (int i = 0; i < 24; i++) begin
      drive_beat(8'h01, 32'(32'hB000_0000 + i), (i == 23));
      tick();
    end
    m_rvalid = 1'b0;
    s_rready = 1'b1;
    repeat (7) tick();
    s_rready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("res_ar2_held_at17", 128'(m_arvalid), 128'(1'b0));
    tick();
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    @(negedge clk);
    chk("res_ar2_lat", 128'(m_arvalid), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("res_ar2_release", 128'(m_arvalid), 128'(1'b1));
    chk("res_ar2_id", 128'(m_arid), 128'(8'h02));
    chk("res_ar2_len", 128'(m_arlen), 128'(8'd15));
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_beat(8'h02, 32'(32'hC000_0000 + i), (i == 15));
      tick();
    end
    m_rvalid = 1'b0;
    drain("res", 100);

    // Simultaneous push and pop at occupancy 10
    for (int i = 0; i < 11; i++) begin
      drive_beat(8'h30, 32'(32'hD000_0000 + i), 1'b0);
      tick();
    end
    m_rvalid = 1'b0;
    @(negedge clk);
    chk("pp_start_count", 128'(fcount), 128'(10));
    tick();
    s_rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m_rvalid = 1'b1;
      m_rid    = 8'($urandom_range(0, 255));
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("pp_count", 128'(fcount), 128'(10));
      tick();
    end
    m_rvalid = 1'b0;
    drain("pp", 100);

    // Asynchronous reset mid-cycle with buffered beats and an AR in flight
    for (int i = 0; i < 5; i++) begin
      drive_beat(8'h40, 32'(32'hE000_0000 + i), 1'b0);
      tick();
    end
    m_rvalid = 1'b0;
    send_ar(8'd3, 8'h33);
    tick();
    chk("pre_rst_arvalid", 128'(m_arvalid), 128'(1'b1));
    chk("pre_rst_rvalid", 128'(s_rvalid), 128'(1'b1));
    chk("pre_rst_count", 128'(fcount), 128'(4));
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_rvalid", 128'(s_rvalid), 128'(1'b0));
    chk("async_rst_arvalid", 128'(m_arvalid), 128'(1'b0));
    chk("async_rst_arready", 128'(s_arready), 128'(1'b0));
    chk("async_rst_count", 128'(fcount), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_arready", 128'(s_arready), 128'(1'b1));
    chk("post_rst_rvalid", 128'(s_rvalid), 128'(1'b0));
    tick();
    // Reservation counter was cleared: a full-depth burst issues immediately
    send_ar(8'd31, 8'h44);
    take_ar("post_rst_full_ar", 8'h44, 3);

    // Pass-through instance: combinational AR and 64-bit beat integrity
    b_s_arvalid = 1'b1; b_s_arid = 4'h3; b_s_araddr = 32'h0000_A000; b_s_arlen = 8'd7;
    b_s_arburst = BURST_WRAP;
    #1;
    chk("b_arvalid_comb", 128'(b_m_arvalid), 128'(1'b1));
    chk("b_arid_comb", 128'(b_m_arid), 128'(4'h3));
    chk("b_araddr_comb", 128'(b_m_araddr), 128'(32'h0000_A000));
    chk("b_arburst_comb", 128'(b_m_arburst), 128'(BURST_WRAP));
    chk("b_arready_low", 128'(b_s_arready), 128'(1'b0));
    b_m_arready = 1'b1;
    #1;
    chk("b_arready_comb", 128'(b_s_arready), 128'(1'b1));
    b_s_arvalid = 1'b0;
    #1;
    chk("b_arvalid_drop", 128'(b_m_arvalid), 128'(1'b0));
    b_m_arready = 1'b0;
    tick();
    b_m_rvalid = 1'b1; b_m_rdata = 64'hDEADBEEF_CAFEF00D; b_m_rid = 4'hA;
    b_m_rresp = RESP_SLVERR; b_m_rlast = 1'b1; b_s_rready = 1'b1;
    tick();
    b_m_rvalid = 1'b0;
    @(negedge clk);
    chk("b_r_lat", 128'(b_s_rvalid), 128'(1'b0));
    tick();
    @(negedge clk);
    chk("b_rvalid", 128'(b_s_rvalid), 128'(1'b1));
    chk("b_rdata", 128'(b_s_rdata), 128'(64'hDEADBEEF_CAFEF00D));
    chk("b_rid", 128'(b_s_rid), 128'(4'hA));
    chk("b_rresp", 128'(b_s_rresp), 128'(RESP_SLVERR));
    chk("b_rlast", 128'(b_s_rlast), 128'(1'b1));
    tick();
    @(negedge clk);
    chk("b_r_taken", 128'(b_s_rvalid), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
